pipe_adder: RTL and testbench

Parametrised, pipelined two-operand adder/subtractor with valid/ready handshake. It generalises the single-bit combinational half adder to a WIDTH-bit datapath, split into STAGES carry-chained slices with one register stage per slice. It adds carry-in, a subtract mode, signed-overflow detection and backpressure. It sits between a data source (counter, register file or shift register) and any consumer that may stall, and is the arithmetic building block for accumulators and dividers.

---
 rtl/pipe_adder_if.sv | 47 ++++
 rtl/pipe_adder.sv | 122 ++++++++++++
 tb/tb_pipe_adder.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// Carries the operand beat (in_*) and the result beat (out_*).
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Source/sink side: offers operands, consumes results.
  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  ovf
  );

  // Adder side.
  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/sub split into STAGES carry-chained slices.
// Ports: sys_clk, rst_n (async, active low), bus (pipe_adder_if.slave).
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic         sys_clk,
  input logic         rst_n,
  pipe_adder_if.slave bus
);
  localparam int SW  = WIDTH / STAGES;
  localparam int OPN = (STAGES > 1) ? STAGES - 1 : 1;

  logic adv;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] cy_q;
  logic [STAGES-1:0] cy_d;
  logic              ovf_q;
  logic              ovf_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  opa_q [OPN];
  logic [WIDTH-1:0]  opa_d [OPN];
  logic [WIDTH-1:0]  opb_q [OPN];
  logic [WIDTH-1:0]  opb_d [OPN];

  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [SW:0]       part  [STAGES];
  logic              c_msb;

  // Global stall: the whole pipe moves only when the output slot frees.
  assign adv = !vld_q[STAGES-1] || bus.out_ready;

  always_comb begin
    // A - B - cin == A + ~B + (1 - cin)
    b_eff    = bus.sub ? ~bus.b : bus.b;
    c0       = bus.sub ? ~bus.cin : bus.cin;

    src_a[0] = bus.a;
    src_b[0] = b_eff;
    src_c[0] = c0;
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = opa_q[k-1];
      src_b[k] = opb_q[k-1];
      src_c[k] = cy_q[k-1];
      src_s[k] = sum_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      part[k] = {1'b0, SW'(src_a[k] >> (k * SW))}
              + {1'b0, SW'(src_b[k] >> (k * SW))}
              + (SW+1)'(src_c[k]);
    end

    // Carry into the MSB recovered from the MSB sum bit.
    c_msb = src_a[STAGES-1][WIDTH-1]
          ^ src_b[STAGES-1][WIDTH-1]
          ^ part[STAGES-1][SW-1];
  end

  always_comb begin
    vld_d = vld_q;
    cy_d  = cy_q;
    ovf_d = ovf_q;
    sum_d = sum_q;
    opa_d = opa_q;
    opb_d = opb_q;
    if (adv) begin
      vld_d[0] = bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k] = vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        // Lower slices above this one are still zero, so OR merges.
        sum_d[k] = src_s[k]
                 | (WIDTH'(part[k][SW-1:0]) << (k * SW));
        cy_d[k]  = part[k][SW];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        opa_d[k] = src_a[k];
        opb_d[k] = src_b[k];
      end
      ovf_d = c_msb ^ part[STAGES-1][SW];
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
      end
      for (int k = 0; k < OPN; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
      sum_q <= sum_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = cy_q[STAGES-1];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: directed vectors, streaming,
// stalls, mid-flight reset and a (WIDTH,STAGES) sweep.
module tb_pipe_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0:(16,4) 1:(8,1) 2:(8,8) 3:(32,4)
  logic        iv   [4];
  logic [31:0] av   [4];
  logic [31:0] bv   [4];
  logic        ci   [4];
  logic        sb   [4];
  logic        ordy [4];
  logic        ir   [4];
  logic        ov   [4];
  logic [31:0] sm   [4];
  logic        co   [4];
  logic        of   [4];

  logic [33:0] sbq  [4][$];
  int          capq [4][$];
  int          adv  [4];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 0) ? 16 : (g == 3) ? 32 : 8;
    localparam int S = (g == 1) ? 1 : (g == 2) ? 8 : 4;
    pipe_adder_if #(.WIDTH(W)) bus ();
    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
      .sys_clk (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave)
    );
    assign bus.in_valid  = iv[g];
    assign bus.a         = av[g][W-1:0];
    assign bus.b         = bv[g][W-1:0];
    assign bus.cin       = ci[g];
    assign bus.sub       = sb[g];
    assign bus.out_ready = ordy[g];
    assign ir[g]         = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign sm[g]         = 32'(bus.sum);
    assign co[g]         = bus.cout;
    assign of[g]         = bus.ovf;
  end

  function automatic int cw(input int i);
    return (i == 0) ? 16 : (i == 3) ? 32 : 8;
  endfunction

  function automatic int cs(input int i);
    return (i == 1) ? 1 : (i == 2) ? 8 : 4;
  endfunction

  function automatic logic [31:0] cmask(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

  // Golden model: {ovf, cout, sum}.
  function automatic logic [33:0] model(input int w,
      input logic [31:0] a, input logic [31:0] b,
      input logic c, input logic s);
    logic [63:0] be;
    logic [63:0] t;
    logic [31:0] r;
    logic        c0;
    logic        cc;
    logic        vv;
    be = s ? (~{32'd0, b}) & {32'd0, cmask(w)} : {32'd0, b};
    c0 = s ? ~c : c;
    t  = {32'd0, a} + be + {63'd0, c0};
    r  = t[31:0] & cmask(w);
    cc = t[w];
    vv = (a[w-1] == be[w-1]) && (r[w-1] != a[w-1]);
    return {vv, cc, r};
  endfunction

  // One clock: drive at negedge, score outputs, push accepted beat.
  task automatic drive_cycle(input int idx, input logic v,
      input logic [31:0] a, input logic [31:0] b,
      input logic c, input logic s, input logic r,
      output logic acc, output logic got);
    logic [33:0] e;
    int          cp;
    logic        irs;
    @(negedge clk);
    iv[idx]   = v;
    av[idx]   = a;
    bv[idx]   = b;
    ci[idx]   = c;
    sb[idx]   = s;
    ordy[idx] = r;
    #1;
    got = ov[idx] && r;
    acc = v && ir[idx];
    irs = ir[idx];
    if (ov[idx]) begin
      n_checks++;
      if (sbq[idx].size() == 0) begin
        n_fail++;
        $display("FAIL stale_out[%0d]: out_valid=1 sum=%h, required none pending",
                 idx, sm[idx]);
      end else if (got) begin
        e  = sbq[idx].pop_front();
        cp = capq[idx].pop_front();
        if ({of[idx], co[idx], sm[idx]} !== e) begin
          n_fail++;
          $display("FAIL result[%0d]: ovf/cout/sum=%b/%b/%h required %b/%b/%h",
                   idx, of[idx], co[idx], sm[idx], e[33], e[32], e[31:0]);
        end
        n_checks++;
        if (adv[idx] - cp != cs(idx) - 1) begin
          n_fail++;
          $display("FAIL latency[%0d]: %0d advancing edges, required %0d",
                   idx, adv[idx] - cp, cs(idx) - 1);
        end
      end
    end
    if (acc) begin
      sbq[idx].push_back(model(cw(idx), a, b, c, s));
      capq[idx].push_back(adv[idx] + 1);
    end
    @(posedge clk);
    if (irs) adv[idx]++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ov[i] !== 1'b0 || sm[i] !== 32'd0 || co[i] !== 1'b0 ||
          of[i] !== 1'b0 || ir[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset[%0d]: v/s/c/o/r=%b/%h/%b/%b/%b required 0/0/0/0/1",
                 i, ov[i], sm[i], co[i], of[i], ir[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] ta [6] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005, 16'h8000, 16'h0010};
    logic [15:0] tb [6] = '{16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h0003};
    logic        tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] es [6] = '{16'h0000, 16'h8000, 16'h1235, 16'hFFFE, 16'h7FFF, 16'h000C};
    logic        ec [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        eo [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic acc;
    logic got;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(0, 1'b1, {16'd0, ta[i]}, {16'd0, tb[i]}, tc[i], ts[i], 1'b1, acc, got);
      repeat (2) drive_cycle(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc, got);
      #2;
      n_checks++;
      if (ov[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL early_valid vec%0d: out_valid=%b required 0", i, ov[0]);
      end
      drive_cycle(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc, got);
      #2;
      n_checks++;
      if (ov[0] !== 1'b1 || sm[0][15:0] !== es[i] || co[0] !== ec[i] || of[0] !== eo[i]) begin
        n_fail++;
        $display("FAIL directed vec%0d: v/sum/cout/ovf=%b/%h/%b/%b required 1/%h/%b/%b",
                 i, ov[0], sm[0][15:0], co[0], of[0], es[i], ec[i], eo[i]);
      end
      drive_cycle(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc, got);
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic got;
    logic have;
    int run;
    int best;
    int seen;
    int sent;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] snap_s;
    logic snap_c;
    logic snap_o;
    logic r;
    run = 0; best = 0; seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        x = $urandom & 32'hFFFF;
        y = $urandom & 32'hFFFF;
        drive_cycle(0, 1'b1, x, y, 1'($urandom), 1'($urandom), 1'b1, acc, got);
        n_checks++;
        if (acc !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_accept beat%0d: accepted=%b required 1", i, acc);
        end
      end else begin
        drive_cycle(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc, got);
      end
      if (got) begin
        run++; seen++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    n_checks++;
    if (seen != 8 || best != 8) begin
      n_fail++;
      $display("FAIL b2b_stream: %0d results, longest run %0d, required 8/8", seen, best);
    end

    // Stream 10 beats with a 3-cycle consumer stall in the middle.
    sent = 0; seen = 0; have = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!have && sent < 10) begin
        x = $urandom & 32'hFFFF;
        y = $urandom & 32'hFFFF;
        have = 1'b1;
      end
      r = !(i >= 6 && i <= 8);
      drive_cycle(0, have, x, y, 1'b0, x[0], r, acc, got);
      if (acc) begin
        have = 1'b0;
        sent++;
      end
      if (got) seen++;
      if (!r) begin
        #2;
        if (i == 6) begin
          snap_s = sm[0]; snap_c = co[0]; snap_o = of[0];
        end
        n_checks++;
        if (ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_ready cyc%0d: in_ready=%b out_valid=%b required 0/1",
                   i, ir[0], ov[0]);
        end
        n_checks++;
        if (sm[0] !== snap_s || co[0] !== snap_c || of[0] !== snap_o) begin
          n_fail++;
          $display("FAIL stall_frozen cyc%0d: sum=%h required %h", i, sm[0], snap_s);
        end
      end
    end
    n_checks++;
    if (sent != 10 || seen != 10 || sbq[0].size() != 0) begin
      n_fail++;
      $display("FAIL stall_count: sent %0d got %0d pending %0d required 10/10/0",
               sent, seen, sbq[0].size());
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    logic got;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 1'b1, 32'h100 + i, 32'h11, 1'b0, 1'b0, 1'b0, acc, got);
    end
    #2;
    n_checks++;
    if (ov[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: out_valid=%b required 1", ov[0]);
    end
    iv[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov[0] !== 1'b0 || sm[0] !== 32'd0 || co[0] !== 1'b0 || of[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: v/sum/cout/ovf=%b/%h/%b/%b required 0/0/0/0",
               ov[0], sm[0], co[0], of[0]);
    end
    for (int i = 0; i < 4; i++) begin
      sbq[i].delete();
      capq[i].delete();
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) drive_cycle(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc, got);
    drive_cycle(0, 1'b1, 32'h0ABC, 32'h1111, 1'b1, 1'b0, 1'b1, acc, got);
    repeat (2) drive_cycle(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc, got);
    #2;
    n_checks++;
    if (ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_early: out_valid=%b required 0", ov[0]);
    end
    drive_cycle(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc, got);
    #2;
    n_checks++;
    if (ov[0] !== 1'b1 || sm[0] !== 32'h1BCE) begin
      n_fail++;
      $display("FAIL post_reset_beat: v/sum=%b/%h required 1/1bce", ov[0], sm[0]);
    end
    drive_cycle(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc, got);
  endtask

  task automatic test_sweep(input int idx);
    logic acc;
    logic got;
    logic have;
    logic [31:0] x;
    logic [31:0] y;
    logic c;
    logic s;
    have = 1'b0;
    x = 0; y = 0; c = 1'b0; s = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!have && $urandom_range(0, 9) < 7) begin
        x = $urandom & cmask(cw(idx));
        y = $urandom & cmask(cw(idx));
        c = 1'($urandom);
        s = 1'($urandom);
        have = 1'b1;
      end
      drive_cycle(idx, have, x, y, c, s, $urandom_range(0, 9) < 7, acc, got);
      if (acc) have = 1'b0;
    end
    for (int i = 0; i < 40 && sbq[idx].size() != 0; i++) begin
      drive_cycle(idx, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc, got);
    end
    n_checks++;
    if (sbq[idx].size() != 0) begin
      n_fail++;
      $display("FAIL sweep_drain[%0d]: %0d beats pending, required 0",
               idx, sbq[idx].size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0; av[i] = '0; bv[i] = '0;
      ci[i] = 1'b0; sb[i] = 1'b0; ordy[i] = 1'b0;
      adv[i] = 0;
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_sweep(1);
    test_sweep(2);
    test_sweep(3);
    test_sweep(0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
